// File: rtl/irq_sequencer_if.sv
// Core/bus-side signal bundle for irq_sequencer.
// master = sequencer side, slave = core/decoder/bus-mux side.
interface irq_sequencer_if #(
    parameter int unsigned NUM_IRQ = 4
) ();
    logic               sync;
    logic               brk;
    logic               nmi;
    logic [NUM_IRQ-1:0] irq;
    logic               i_flag;
    logic [15:0]        pc_in;
    logic [7:0]         sp_in;
    logic [7:0]         p_in;
    logic [7:0]         rdata;
    logic [15:0]        addr;
    logic [7:0]         wdata;
    logic               rw;
    logic               busy;
    logic               set_i;
    logic               pc_load;
    logic [15:0]        pc_out;
    logic               sp_load;
    logic [7:0]         sp_out;
    logic [NUM_IRQ-1:0] irq_ack;

    modport master (
        input  sync, brk, nmi, irq, i_flag, pc_in, sp_in, p_in, rdata,
        output addr, wdata, rw, busy, set_i, pc_load, pc_out, sp_load, sp_out, irq_ack
    );

    modport slave (
        output sync, brk, nmi, irq, i_flag, pc_in, sp_in, p_in, rdata,
        input  addr, wdata, rw, busy, set_i, pc_load, pc_out, sp_load, sp_out, irq_ack
    );
endinterface

// File: rtl/irq_sequencer.sv
// Reset/NMI/BRK/IRQ entry sequencer: pushes PC and P, fetches the vector, hands PC/SP back.
// Optional macro IRQ_VECTORED_EN: IRQ sources vector through IRQ_TABLE + 2*idx.
//
// state      | meaning
// IDLE       | waiting for sync with a pending source; addr follows pc_in
// PUSH_PCH   | write PC high byte to stack (suppressed for reset)
// PUSH_PCL   | write PC low byte to stack (suppressed for reset)
// PUSH_P     | write status byte to stack (suppressed for reset)
// VEC_LO     | read vector low byte, strobe set_i, retire pending flag
// VEC_HI     | read vector high byte
// DONE       | present pc_out/sp_out with load strobes and irq_ack
module irq_sequencer #(
    parameter int unsigned NUM_IRQ    = 4,
    parameter logic [15:0] VEC_BASE   = 16'hFFFA,
    parameter logic [7:0]  STACK_PAGE = 8'h01,
    parameter logic [15:0] IRQ_TABLE  = 16'hFFE0
) (
    input logic             clk,
    input logic             clr,
    irq_sequencer_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE, S_PUSH_PCH, S_PUSH_PCL, S_PUSH_P, S_VEC_LO, S_VEC_HI, S_DONE
    } state_t;

    typedef enum logic [1:0] {
        SRC_RESET, SRC_NMI, SRC_BRK, SRC_IRQ
    } src_t;

    state_t             state_q, state_d;
    src_t               src_q, src_d;
    logic [15:0]        pc_q, pc_d;
    logic [7:0]         sp_q, sp_d;
    logic [7:0]         lo_q, lo_d;
    logic [7:0]         hi_q, hi_d;
    logic [15:0]        vec_q, vec_d;
    logic [NUM_IRQ-1:0] ack_q, ack_d;
    logic               nmi_pend_q, nmi_pend_d;
    logic               reset_pend_q, reset_pend_d;
    logic               nmi_prev_q;

    logic [NUM_IRQ-1:0] irq_masked;
    logic [NUM_IRQ-1:0] irq_first;
    logic               irq_any;
    logic               accept;
    logic               nmi_rise;
    logic [15:0]        vec_sel;

    assign irq_masked = bus.irq & {NUM_IRQ{~bus.i_flag}};
    assign irq_any    = |irq_masked;
    // Isolate the lowest set bit: x & -x
    assign irq_first  = irq_masked & (~irq_masked + NUM_IRQ'(1));
    assign accept     = (state_q == S_IDLE) && bus.sync &&
                        (reset_pend_q || nmi_pend_q || bus.brk || irq_any);
    assign nmi_rise   = bus.nmi & ~nmi_prev_q;

`ifdef IRQ_VECTORED_EN
    logic [2:0] first_idx;
    logic [2:0] idx_q, idx_d;

    always_comb begin
        first_idx = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (irq_masked[i]) first_idx = 3'(i);
        end
    end
`else
    logic unused_irq_table;
    assign unused_irq_table = ^IRQ_TABLE;
`endif

    // A pending NMI seen at VEC_LO of an IRQ/BRK sequence hijacks the vector.
    always_comb begin
        vec_sel = VEC_BASE + 16'd4;
        if (src_q == SRC_RESET) begin
            vec_sel = VEC_BASE + 16'd2;
        end else if (src_q == SRC_NMI || nmi_pend_q) begin
            vec_sel = VEC_BASE;
        end else if (src_q == SRC_IRQ) begin
`ifdef IRQ_VECTORED_EN
            vec_sel = IRQ_TABLE + {12'd0, idx_q, 1'b0};
`else
            vec_sel = VEC_BASE + 16'd4;
`endif
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q      <= S_IDLE;
            src_q        <= SRC_RESET;
            pc_q         <= '0;
            sp_q         <= '0;
            lo_q         <= '0;
            hi_q         <= '0;
            vec_q        <= '0;
            ack_q        <= '0;
            nmi_pend_q   <= 1'b0;
            reset_pend_q <= 1'b1;
            nmi_prev_q   <= 1'b0;
`ifdef IRQ_VECTORED_EN
            idx_q        <= '0;
`endif
        end else begin
            state_q      <= state_d;
            src_q        <= src_d;
            pc_q         <= pc_d;
            sp_q         <= sp_d;
            lo_q         <= lo_d;
            hi_q         <= hi_d;
            vec_q        <= vec_d;
            ack_q        <= ack_d;
            nmi_pend_q   <= nmi_pend_d;
            reset_pend_q <= reset_pend_d;
            nmi_prev_q   <= bus.nmi;
`ifdef IRQ_VECTORED_EN
            idx_q        <= idx_d;
`endif
        end
    end

    always_comb begin
        state_d      = state_q;
        src_d        = src_q;
        pc_d         = pc_q;
        sp_d         = sp_q;
        lo_d         = lo_q;
        hi_d         = hi_q;
        vec_d        = vec_q;
        ack_d        = ack_q;
        nmi_pend_d   = nmi_pend_q;
        reset_pend_d = reset_pend_q;
`ifdef IRQ_VECTORED_EN
        idx_d        = idx_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_PUSH_PCH;
                    sp_d    = bus.sp_in;
                    pc_d    = bus.pc_in;
                    ack_d   = '0;
`ifdef IRQ_VECTORED_EN
                    idx_d   = first_idx;
`endif
                    if (reset_pend_q) begin
                        src_d = SRC_RESET;
                    end else if (nmi_pend_q) begin
                        src_d = SRC_NMI;
                    end else if (bus.brk) begin
                        src_d = SRC_BRK;
                        pc_d  = bus.pc_in + 16'd1;
                    end else begin
                        src_d = SRC_IRQ;
                        ack_d = irq_first;
                    end
                end
            end
            S_PUSH_PCH: begin
                state_d = S_PUSH_PCL;
                sp_d    = sp_q - 8'd1;
            end
            S_PUSH_PCL: begin
                state_d = S_PUSH_P;
                sp_d    = sp_q - 8'd1;
            end
            S_PUSH_P: begin
                state_d = S_VEC_LO;
                sp_d    = sp_q - 8'd1;
            end
            S_VEC_LO: begin
                state_d = S_VEC_HI;
                lo_d    = bus.rdata;
                vec_d   = vec_sel;
                if (src_q == SRC_RESET) begin
                    reset_pend_d = 1'b0;
                end else if (src_q == SRC_NMI || nmi_pend_q) begin
                    nmi_pend_d = 1'b0;
                end
            end
            S_VEC_HI: begin
                state_d = S_DONE;
                hi_d    = bus.rdata;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // A fresh edge always wins over the VEC_LO clear so it stays pending.
        if (nmi_rise) nmi_pend_d = 1'b1;
    end

    always_comb begin
        bus.addr    = bus.pc_in;
        bus.wdata   = 8'h00;
        bus.rw      = 1'b0;
        bus.busy    = (state_q != S_IDLE);
        bus.set_i   = 1'b0;
        bus.pc_load = 1'b0;
        bus.pc_out  = 16'h0000;
        bus.sp_load = 1'b0;
        bus.sp_out  = 8'h00;
        bus.irq_ack = '0;
        case (state_q)
            S_PUSH_PCH: begin
                bus.addr  = {STACK_PAGE, sp_q};
                bus.wdata = pc_q[15:8];
                bus.rw    = (src_q != SRC_RESET);
            end
            S_PUSH_PCL: begin
                bus.addr  = {STACK_PAGE, sp_q};
                bus.wdata = pc_q[7:0];
                bus.rw    = (src_q != SRC_RESET);
            end
            S_PUSH_P: begin
                bus.addr  = {STACK_PAGE, sp_q};
                bus.wdata = (bus.p_in & 8'hCF) | 8'h20 |
                            ((src_q == SRC_BRK) ? 8'h10 : 8'h00);
                bus.rw    = (src_q != SRC_RESET);
            end
            S_VEC_LO: begin
                bus.addr  = vec_sel;
                bus.set_i = 1'b1;
            end
            S_VEC_HI: begin
                bus.addr = vec_q + 16'd1;
            end
            S_DONE: begin
                bus.pc_out  = {hi_q, lo_q};
                bus.sp_out  = sp_q;
                bus.pc_load = 1'b1;
                bus.sp_load = 1'b1;
                bus.irq_ack = ack_q;
            end
            default: ;
        endcase
    end

endmodule
